// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: MEM -> WB stage bundle.
//   master : MEM side, drives stall/flush and the in_* fields, observes the write port
//   slave  : the MEM/WB stage itself
// Ports carried:
//   stall, flush                      stage control
//   in_valid, in_reg_write, in_rd,
//   in_wb_sel, in_funct3,
//   in_alu_result, in_mem_rdata,
//   in_pc_plus4                       memory-stage results
//   wr_en, wr_addr, wr_data           register file write port
//   out_valid, fwd_rd, fwd_we         status / forwarding copies
interface mem_wb_stage_if;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic        in_reg_write;
    logic [4:0]  in_rd;
    logic [1:0]  in_wb_sel;
    logic [2:0]  in_funct3;
    logic [31:0] in_alu_result;
    logic [31:0] in_mem_rdata;
    logic [31:0] in_pc_plus4;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        out_valid;
    logic [4:0]  fwd_rd;
    logic        fwd_we;

    modport master (
        output stall, flush, in_valid, in_reg_write, in_rd, in_wb_sel, in_funct3,
               in_alu_result, in_mem_rdata, in_pc_plus4,
        input  wr_en, wr_addr, wr_data, out_valid, fwd_rd, fwd_we
    );

    modport slave (
        input  stall, flush, in_valid, in_reg_write, in_rd, in_wb_sel, in_funct3,
               in_alu_result, in_mem_rdata, in_pc_plus4,
        output wr_en, wr_addr, wr_data, out_valid, fwd_rd, fwd_we
    );
endinterface

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register and writeback mux (RV32I).
// Registers the memory-stage results, picks the writeback source and extends loads.
// Ports:
//   clk       pipeline clock, rising edge
//   rst       synchronous active-high reset
//   bus       mem_wb_stage_if.slave (stall/flush, in_* fields, register file write port,
//             out_valid, fwd_rd/fwd_we)
//   instret   64-bit retired-instruction counter, only when MEM_WB_RETIRE_CNT_EN is defined
// Optional feature macro: MEM_WB_RETIRE_CNT_EN
module mem_wb_stage #(
    parameter int unsigned           XLEN    = 32,
    parameter logic [XLEN-1:0]       RST_PC4 = '0
) (
    input  logic                clk,
    input  logic                rst,
    mem_wb_stage_if.slave       bus
`ifdef MEM_WB_RETIRE_CNT_EN
    ,
    output logic [63:0]         instret
`endif
);

    logic            r_valid;
    logic            r_reg_write;
    logic [4:0]      r_rd;
    logic [1:0]      r_wb_sel;
    logic [2:0]      r_funct3;
    logic [XLEN-1:0] r_alu;
    logic [XLEN-1:0] r_rdata;
    logic [XLEN-1:0] r_pc4;

    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_load;
    logic [XLEN-1:0] w_wr_data;
    logic            w_wr_en;

    // Flush only clears valid; the data fields are don't-care, so they capture as usual.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_rd        <= '0;
            r_wb_sel    <= '0;
            r_funct3    <= '0;
            r_alu       <= '0;
            r_rdata     <= '0;
            r_pc4       <= RST_PC4;
        end else if (!bus.stall) begin
            r_valid     <= bus.in_valid & ~bus.flush;
            r_reg_write <= bus.in_reg_write;
            r_rd        <= bus.in_rd;
            r_wb_sel    <= bus.in_wb_sel;
            r_funct3    <= bus.in_funct3;
            r_alu       <= bus.in_alu_result;
            r_rdata     <= bus.in_mem_rdata;
            r_pc4       <= bus.in_pc_plus4;
        end
    end

    // Little-endian lane select; halfword ignores off[0] (misalignment trapped upstream).
    always_comb begin
        w_byte = r_rdata[7:0];
        unique case (r_alu[1:0])
            2'd0: w_byte = r_rdata[7:0];
            2'd1: w_byte = r_rdata[15:8];
            2'd2: w_byte = r_rdata[23:16];
            2'd3: w_byte = r_rdata[31:24];
        endcase
        w_half = r_alu[1] ? r_rdata[31:16] : r_rdata[15:0];
    end

    always_comb begin
        w_load = r_rdata;
        case (r_funct3)
            3'b000:  w_load = {{(XLEN-8){w_byte[7]}}, w_byte};
            3'b100:  w_load = {{(XLEN-8){1'b0}}, w_byte};
            3'b001:  w_load = {{(XLEN-16){w_half[15]}}, w_half};
            3'b101:  w_load = {{(XLEN-16){1'b0}}, w_half};
            default: w_load = r_rdata;  // LW and undefined encodings
        endcase
    end

    always_comb begin
        w_wr_data = '0;
        unique case (r_wb_sel)
            2'b00: w_wr_data = r_alu;
            2'b01: w_wr_data = w_load;
            2'b10: w_wr_data = r_pc4;
            2'b11: w_wr_data = '0;
        endcase
    end

    // x0 writes and the reserved source are suppressed here, not upstream.
    assign w_wr_en = r_valid & r_reg_write & (r_rd != 5'd0) & (r_wb_sel != 2'b11);

    assign bus.wr_en     = w_wr_en;
    assign bus.wr_addr   = r_rd;
    assign bus.wr_data   = w_wr_data;
    assign bus.out_valid = r_valid;
    assign bus.fwd_rd    = r_rd;
    assign bus.fwd_we    = w_wr_en;

`ifdef MEM_WB_RETIRE_CNT_EN
    logic [63:0] r_instret;

    // An instruction retires when it leaves the stage: valid and not held by stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instret <= '0;
        end else if (r_valid && !bus.stall) begin
            r_instret <= r_instret + 64'd1;
        end
    end

    assign instret = r_instret;
`endif

endmodule
